// File: rtl/cam_i2c_pkg.sv
// ---------------------------------------------------------------------------
// cam_i2c_pkg
// Shared constants for the camera SCCB/I2C register writer.
//  - state_t / ST_*   : write engine FSM state encodings
//  - N_BYTES          : bytes per command (addr+W, reg hi, reg lo, data)
//  - BITS_PER_BYTE    : data bits per byte before the ACK slot
//  - Q0..Q3           : quarter-bit phase numbers
//  - START_Q / STOP_Q : number of quarters spent in START and STOP
//  - pack_cmd()       : builds the 32-bit shift word for one command
// ---------------------------------------------------------------------------
package cam_i2c_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_START = 3'd1;
   localparam state_t ST_BIT   = 3'd2;
   localparam state_t ST_ACK   = 3'd3;
   localparam state_t ST_STOP  = 3'd4;

   localparam int N_BYTES       = 4;
   localparam int BITS_PER_BYTE = 8;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   localparam int START_Q = 4;
   localparam int STOP_Q  = 4;

   // The shift word goes out MSB first: 7-bit address with the write bit
   // (0) appended, then the register address high/low, then the data byte.
   function automatic logic [31:0] pack_cmd(input logic [6:0]  addr7,
                                            input logic [15:0] reg_addr,
                                            input logic [7:0]  data);
      return {addr7, 1'b0, reg_addr, data};
   endfunction

endpackage

// File: rtl/cam_i2c_reg_writer_qtick.sv
// ---------------------------------------------------------------------------
// cam_i2c_qtick
// Quarter-bit timebase for the write engine. Divides clk400 by QDIV and
// steps a 2-bit quarter counter; the counter freezes while the engine has
// released scl but the bus still reads low (slave clock stretching).
// Ports:
//  clk400       in   timebase clock
//  reset_n      in   asynchronous active-low reset
//  run          in   1 while a transfer is in progress; 0 parks at Q0
//  scl_released in   1 while the engine is not pulling scl low
//  scl_in       in   resolved scl bus level
//  quarter      out  current quarter of the bit (Q0..Q3)
//  qend         out  1 in the last clk400 cycle of the current quarter
// ---------------------------------------------------------------------------
module cam_i2c_qtick
   import cam_i2c_pkg::*;
#(
   parameter int QDIV       = 1,
   parameter bit STRETCH_EN = 1'b1
) (
   input  logic       clk400,
   input  logic       reset_n,
   input  logic       run,
   input  logic       scl_released,
   input  logic       scl_in,
   output logic [1:0] quarter,
   output logic       qend
);

   localparam int DW = (QDIV > 1) ? $clog2(QDIV) : 1;

   logic [DW-1:0] div_cnt;
   logic          freeze;

   // A released scl that still reads low means a slave is holding the clock,
   // so time must not advance until it lets go.
   assign freeze = STRETCH_EN && scl_released && !scl_in;
   assign qend   = run && !freeze && (div_cnt == DW'(QDIV - 1));

   // Divider and quarter counter. Both park at zero while idle so that the
   // first quarter after an accept always lasts a full QDIV cycles.
   always_ff @(posedge clk400 or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= '0;
         quarter <= Q0;
      end else if (!run) begin
         div_cnt <= '0;
         quarter <= Q0;
      end else if (!freeze) begin
         if (qend) begin
            div_cnt <= '0;
            quarter <= quarter + 2'd1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/cam_i2c_reg_writer.sv
// ---------------------------------------------------------------------------
// cam_i2c_reg_writer
// Open-drain SCCB/I2C write engine fed by the camera init sequencer. Each
// accepted command sends START, addr+W, reg[15:8], reg[7:0], data, STOP and
// then raises ready again.
// Ports:
//  clk400       in     I2C timebase clock
//  reset_n      in     asynchronous active-low reset
//  send_data    in     command strobe, taken only while ready=1
//  slave_addr   in     7-bit slave address in [6:0]; [7] unused
//  register_in  in     16-bit register address, MSB first on the bus
//  datain       in     data byte written to the register
//  ackn         in     1: carry on through slave NACKs; 0: abort on NACK
//  scl          inout  open-drain clock (0 or Z)
//  sda          inout  open-drain data (0 or Z)
//  ready        out    1 while idle and able to accept a command
//  nack_err     out    sticky NACK flag, cleared by the next accept
// ---------------------------------------------------------------------------
module cam_i2c_reg_writer
   import cam_i2c_pkg::*;
#(
   parameter int QDIV       = 1,
   parameter bit STRETCH_EN = 1'b1
) (
   input  logic        clk400,
   input  logic        reset_n,
   input  logic        send_data,
   input  logic [7:0]  slave_addr,
   input  logic [15:0] register_in,
   input  logic [7:0]  datain,
   input  logic        ackn,
   inout  wire         scl,
   inout  wire         sda,
   output logic        ready,
   output logic        nack_err
);

   logic [1:0]  rst_pipe;
   logic        rst_n_sync;
   state_t      state;
   logic [31:0] shreg;
   logic [2:0]  bit_cnt;
   logic [1:0]  byte_cnt;
   logic        ackn_q;
   logic        nack_seen;
   logic [1:0]  quarter;
   logic        qend;
   logic        scl_low;
   logic        sda_low;
   logic        unused_addr_msb;

   assign unused_addr_msb = slave_addr[7];

   // Reset asserts asynchronously but releases on a clock edge, so the FSM
   // never leaves reset part-way through a cycle.
   always_ff @(posedge clk400 or negedge reset_n) begin
      if (!reset_n) begin
         rst_pipe <= 2'b00;
      end else begin
         rst_pipe <= {rst_pipe[0], 1'b1};
      end
   end

   assign rst_n_sync = rst_pipe[1];

   cam_i2c_qtick #(
      .QDIV       (QDIV),
      .STRETCH_EN (STRETCH_EN)
   ) u_qtick (
      .clk400       (clk400),
      .reset_n      (rst_n_sync),
      .run          (state != ST_IDLE),
      .scl_released (!scl_low),
      .scl_in       (scl),
      .quarter      (quarter),
      .qend         (qend)
   );

   // Line drive is decoded straight from state and quarter. Reset forces the
   // state to IDLE, which releases both lines in the same instant. sda only
   // moves while scl is low, apart from the START fall and the STOP rise.
   always_comb begin
      scl_low = 1'b0;
      sda_low = 1'b0;
      case (state)
         ST_START: begin
            sda_low = (quarter != Q0);
            scl_low = (quarter == Q3);
         end
         ST_BIT: begin
            sda_low = !shreg[31];
            scl_low = (quarter == Q0) || (quarter == Q3);
         end
         ST_ACK: begin
            scl_low = (quarter == Q0) || (quarter == Q3);
         end
         ST_STOP: begin
            sda_low = (quarter == Q0) || (quarter == Q1);
            scl_low = (quarter == Q0);
         end
         default: begin
            scl_low = 1'b0;
            sda_low = 1'b0;
         end
      endcase
   end

   assign scl   = scl_low ? 1'b0 : 1'bz;
   assign sda   = sda_low ? 1'b0 : 1'bz;
   assign ready = (state == ST_IDLE);

   // Write sequencer. All command fields, including ackn, are captured at
   // accept so later input changes cannot disturb the transfer in flight.
   // The ACK level is sampled at the end of Q2 (scl high) and acted on at
   // the end of Q3, once scl is low again.
   always_ff @(posedge clk400 or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         state     <= ST_IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         byte_cnt  <= '0;
         ackn_q    <= 1'b0;
         nack_seen <= 1'b0;
         nack_err  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (send_data) begin
                  shreg     <= pack_cmd(slave_addr[6:0], register_in, datain);
                  ackn_q    <= ackn;
                  nack_err  <= 1'b0;
                  nack_seen <= 1'b0;
                  bit_cnt   <= '0;
                  byte_cnt  <= '0;
                  state     <= ST_START;
               end
            end
            ST_START: begin
               if (qend && (quarter == 2'(START_Q - 1))) begin
                  state <= ST_BIT;
               end
            end
            ST_BIT: begin
               if (qend && (quarter == Q3)) begin
                  shreg <= {shreg[30:0], 1'b0};
                  if (bit_cnt == 3'(BITS_PER_BYTE - 1)) begin
                     bit_cnt <= '0;
                     state   <= ST_ACK;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end
            end
            ST_ACK: begin
               if (qend && (quarter == Q2)) begin
                  nack_seen <= sda;
               end else if (qend && (quarter == Q3)) begin
                  if (nack_seen && !ackn_q) begin
                     nack_err <= 1'b1;
                     state    <= ST_STOP;
                  end else if (byte_cnt == 2'(N_BYTES - 1)) begin
                     state <= ST_STOP;
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                     state    <= ST_BIT;
                  end
               end
            end
            ST_STOP: begin
               if (qend && (quarter == 2'(STOP_Q - 1))) begin
                  state <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cam_i2c_reg_writer.sv
// ---------------------------------------------------------------------------
// tb_cam_i2c_reg_writer
// Two writers (QDIV=1 and QDIV=3) share one pulled-up bus with a behavioural
// slave that decodes START/STOP, collects bytes, ACKs (or NACKs a chosen
// byte) and can be made to hold scl low. Directed steps, hand-computed
// expectations. Clock period 10 time units.
// ---------------------------------------------------------------------------
module tb_cam_i2c_reg_writer;

   logic        clk400 = 1'b0;
   logic        reset_n;
   logic        send1, send3;
   logic [7:0]  slave_addr;
   logic [15:0] register_in;
   logic [7:0]  datain;
   logic        ackn;
   logic        ready1, ready3, nack1, nack3;
   wire         scl, sda;

   logic        scl_pull = 1'b0;
   logic        sda_pull = 1'b0;

   int          checks = 0;
   int          errors = 0;

   int          starts, stops, s_bits, s_nbytes, nack_byte;
   logic        s_acking;
   logic [7:0]  s_shift;
   logic [7:0]  rx [4];
   time         t_start, t_stop, t_accept;
   time         rise_t [8];
   int          rise_n;
   int          low1, low3;

   always #5 clk400 = ~clk400;

   pullup (scl);
   pullup (sda);
   assign scl = scl_pull ? 1'b0 : 1'bz;
   assign sda = sda_pull ? 1'b0 : 1'bz;

   cam_i2c_reg_writer #(.QDIV(1), .STRETCH_EN(1'b1)) u_dut1 (
      .clk400(clk400), .reset_n(reset_n), .send_data(send1),
      .slave_addr(slave_addr), .register_in(register_in), .datain(datain),
      .ackn(ackn), .scl(scl), .sda(sda), .ready(ready1), .nack_err(nack1)
   );

   cam_i2c_reg_writer #(.QDIV(3), .STRETCH_EN(1'b1)) u_dut3 (
      .clk400(clk400), .reset_n(reset_n), .send_data(send3),
      .slave_addr(slave_addr), .register_in(register_in), .datain(datain),
      .ackn(ackn), .scl(scl), .sda(sda), .ready(ready3), .nack_err(nack3)
   );

   // Busy-cycle counters, sampled away from the active edge
   always @(negedge clk400) begin
      if (ready1 === 1'b0) low1++;
      if (ready3 === 1'b0) low3++;
   end

   // Slave: START / STOP detection
   always @(negedge sda) begin
      if (scl === 1'b1) begin
         starts++;
         t_start  = $time;
         s_bits   = 0;
         s_nbytes = 0;
         s_acking = 1'b0;
         sda_pull = 1'b0;
      end
   end

   always @(posedge sda) begin
      if (scl === 1'b1) begin
         stops++;
         t_stop = $time;
      end
   end

   // Slave: sample data on scl rise, record rise times
   always @(posedge scl) begin
      if (rise_n < 8) begin
         rise_t[rise_n] = $time;
         rise_n++;
      end
      if (s_bits < 8) begin
         s_shift = {s_shift[6:0], sda};
         s_bits++;
      end
   end

   // Slave: enter/leave the ACK slot on scl fall
   always @(negedge scl) begin
      if (s_acking) begin
         sda_pull = 1'b0;
         s_acking = 1'b0;
         s_bits   = 0;
      end else if (s_bits == 8) begin
         if (s_nbytes < 4) rx[s_nbytes] = s_shift;
         sda_pull = (s_nbytes != nack_byte);
         s_nbytes++;
         s_acking = 1'b1;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit sel3, input logic [7:0] a,
                                input logic [15:0] r, input logic [7:0] d,
                                input logic ack_ign);
      @(negedge clk400);
      slave_addr  = a;
      register_in = r;
      datain      = d;
      ackn        = ack_ign;
      low1 = 0; low3 = 0; starts = 0; stops = 0; rise_n = 0;
      for (int i = 0; i < 4; i++) rx[i] = 8'hEE;
      if (sel3) send3 = 1'b1;
      else      send1 = 1'b1;
      @(posedge clk400);
      t_accept = $time;
      @(negedge clk400);
      send1 = 1'b0;
      send3 = 1'b0;
   endtask

   task automatic waitIdle(input bit sel3);
      int n = 0;
      while (((sel3 ? ready3 : ready1) !== 1'b1) && (n < 3000)) begin
         @(negedge clk400);
         n++;
      end
      checkOutput("ready_returns", 32'(n < 3000), 32'd1);
   endtask

   initial begin
      reset_n = 1'b0; send1 = 1'b0; send3 = 1'b0;
      slave_addr = '0; register_in = '0; datain = '0; ackn = 1'b0;
      nack_byte = -1; s_acking = 1'b0; s_bits = 0; s_nbytes = 0; s_shift = '0;
      starts = 0; stops = 0; rise_n = 0; low1 = 0; low3 = 0;
      t_start = 0; t_stop = 0; t_accept = 0;

      $display("[TB] reset state");
      repeat (3) @(negedge clk400);
      checkOutput("rst_ready1", 32'(ready1), 32'd1);
      checkOutput("rst_ready3", 32'(ready3), 32'd1);
      checkOutput("rst_nack1", 32'(nack1), 32'd0);
      checkOutput("rst_scl", 32'(scl), 32'd1);
      checkOutput("rst_sda", 32'(sda), 32'd1);
      reset_n = 1'b1;
      repeat (5) @(negedge clk400);

      $display("[TB] basic write, QDIV=1");
      applyStimulus(1'b0, 8'h10, 16'h0100, 8'h01, 1'b0);
      repeat (30) @(negedge clk400);
      checkOutput("t1_busy_ready", 32'(ready1), 32'd0);
      slave_addr = 8'h7F; register_in = 16'hFFFF; datain = 8'hFF; send1 = 1'b1;
      @(negedge clk400);
      send1 = 1'b0;
      waitIdle(1'b0);
      checkOutput("t1_low", 32'(low1), 32'd152);
      checkOutput("t1_b0", 32'(rx[0]), 32'h20);
      checkOutput("t1_b1", 32'(rx[1]), 32'h01);
      checkOutput("t1_b2", 32'(rx[2]), 32'h00);
      checkOutput("t1_b3", 32'(rx[3]), 32'h01);
      checkOutput("t1_nack", 32'(nack1), 32'd0);
      checkOutput("t1_starts", 32'(starts), 32'd1);
      checkOutput("t1_stops", 32'(stops), 32'd1);
      checkOutput("t1_start_t", 32'(t_start - t_accept), 32'd10);
      checkOutput("t1_rise0_t", 32'(rise_t[0] - t_accept), 32'd50);
      checkOutput("t1_stop_t", 32'(t_stop - t_accept), 32'd1500);

      $display("[TB] write with QDIV=3");
      applyStimulus(1'b1, 8'h10, 16'h3034, 8'h1A, 1'b0);
      waitIdle(1'b1);
      checkOutput("t2_low", 32'(low3), 32'd456);
      checkOutput("t2_b0", 32'(rx[0]), 32'h20);
      checkOutput("t2_b1", 32'(rx[1]), 32'h30);
      checkOutput("t2_b2", 32'(rx[2]), 32'h34);
      checkOutput("t2_b3", 32'(rx[3]), 32'h1A);
      checkOutput("t2_nack", 32'(nack3), 32'd0);
      checkOutput("t2_start_t", 32'(t_start - t_accept), 32'd30);
      checkOutput("t2_rise0_t", 32'(rise_t[0] - t_accept), 32'd150);
      checkOutput("t2_scl_period", 32'(rise_t[1] - rise_t[0]), 32'd120);
      checkOutput("t2_stops", 32'(stops), 32'd1);
      checkOutput("t2_stop_t", 32'(t_stop - t_accept), 32'd4500);

      $display("[TB] NACK on byte 1, abort enabled");
      nack_byte = 1;
      applyStimulus(1'b0, 8'h3C, 16'h1234, 8'h56, 1'b0);
      waitIdle(1'b0);
      checkOutput("t3_low", 32'(low1), 32'd80);
      checkOutput("t3_nack", 32'(nack1), 32'd1);
      checkOutput("t3_nbytes", 32'(s_nbytes), 32'd2);
      checkOutput("t3_b0", 32'(rx[0]), 32'h78);
      checkOutput("t3_b1", 32'(rx[1]), 32'h12);
      checkOutput("t3_stops", 32'(stops), 32'd1);
      checkOutput("t3_stop_t", 32'(t_stop - t_accept), 32'd780);

      $display("[TB] NACK on byte 1, NACKs ignored");
      applyStimulus(1'b0, 8'h3C, 16'h1234, 8'h56, 1'b1);
      checkOutput("t4_nack_cleared", 32'(nack1), 32'd0);
      waitIdle(1'b0);
      checkOutput("t4_low", 32'(low1), 32'd152);
      checkOutput("t4_nack", 32'(nack1), 32'd0);
      checkOutput("t4_nbytes", 32'(s_nbytes), 32'd4);
      checkOutput("t4_b2", 32'(rx[2]), 32'h34);
      checkOutput("t4_b3", 32'(rx[3]), 32'h56);
      checkOutput("t4_stop_t", 32'(t_stop - t_accept), 32'd1500);
      nack_byte = -1;

      $display("[TB] clock stretch in byte 2 bit 5");
      applyStimulus(1'b0, 8'h21, 16'hA5C3, 8'h7E, 1'b0);
      repeat (96) @(posedge clk400);
      #1 scl_pull = 1'b1;
      repeat (21) @(posedge clk400);
      #1 scl_pull = 1'b0;
      waitIdle(1'b0);
      checkOutput("t5_low", 32'(low1), 32'd172);
      checkOutput("t5_b0", 32'(rx[0]), 32'h42);
      checkOutput("t5_b1", 32'(rx[1]), 32'hA5);
      checkOutput("t5_b2", 32'(rx[2]), 32'hC3);
      checkOutput("t5_b3", 32'(rx[3]), 32'h7E);
      checkOutput("t5_stop_t", 32'(t_stop - t_accept), 32'd1700);

      $display("[TB] reset during byte 1");
      applyStimulus(1'b0, 8'h10, 16'h8000, 8'h55, 1'b0);
      repeat (40) @(posedge clk400);
      #1;
      checkOutput("t6_scl_driven", 32'(scl), 32'd0);
      #1 reset_n = 1'b0;
      #1;
      checkOutput("t6_scl_rel", 32'(scl), 32'd1);
      checkOutput("t6_sda_rel", 32'(sda), 32'd1);
      checkOutput("t6_ready", 32'(ready1), 32'd1);
      checkOutput("t6_no_stop", 32'(stops), 32'd0);
      repeat (2) @(negedge clk400);
      reset_n = 1'b1;
      repeat (5) @(negedge clk400);
      checkOutput("t6_nack", 32'(nack1), 32'd0);

      applyStimulus(1'b0, 8'h48, 16'h0F0F, 8'hC5, 1'b0);
      waitIdle(1'b0);
      checkOutput("t7_low", 32'(low1), 32'd152);
      checkOutput("t7_b0", 32'(rx[0]), 32'h90);
      checkOutput("t7_b1", 32'(rx[1]), 32'h0F);
      checkOutput("t7_b2", 32'(rx[2]), 32'h0F);
      checkOutput("t7_b3", 32'(rx[3]), 32'hC5);
      checkOutput("t7_starts", 32'(starts), 32'd1);
      checkOutput("t7_stops", 32'(stops), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
